muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative multiply/divide unit for the execute stage.
- Sits directly downstream of the register file:
  - Consumes the two read operands (`Data1`, `Data2`).
  - Produces 2W-bit HI/LO results, which later instructions move back through the register-file write port.
- Algorithm: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
- Uses a start/busy/done handshake, so the control unit stalls while `busy` is high.

## Interface

Parameters
- `W`, default 32: operand and result-half width.

Ports
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only while idle.
- `op`  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  input  W  first operand (register-file `Data1`); multiplicand or dividend.
- `B`  input  W  second operand (register-file `Data2`); multiplier or divisor.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when HI/LO are updated.
- `hi`  output  W  upper product half or remainder.
- `lo`  output  W  lower product half or quotient.
- `dz`  output  1  divide by zero; valid with `done`, held until the next `done`.

## Operation

- States: IDLE, RUN, FIX. `busy` is combinational: `state != IDLE`.
- IDLE:
  - On an edge with `start=1`, latch `op`, the operand magnitudes (absolute values for signed ops) and the result signs.
  - Clear the step counter and go to RUN.
  - Otherwise stay in IDLE.
- RUN: one iteration per edge.
  - Multiply: if the LSB of the multiplier is set, add the multiplicand into the upper accumulator, then shift the 2W+1-bit accumulator right by one.
  - Divide: shift the {rem, quot} pair left by one, trial-subtract the divisor from rem, and set the quotient LSB when the result is non-negative.
  - After the W-th iteration, go to FIX.
- FIX: one edge, then go to IDLE. On that edge:
  - Apply the sign correction.
  - Write `hi`/`lo`.
  - Set `done=1` and update `dz`.
- Sign rules:
  - MULT: negate the 2W-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (B==0, DIV or DIVU):
  - `lo` = all ones, `hi` = A (original, unsigned-as-given), `dz=1`.
  - Latency is unchanged.
- Signed overflow (DIV of -2^(W-1) by -1): `lo` = -2^(W-1), `hi` = 0, `dz=0`.
- `hi`/`lo` change only on the FIX edge. Working registers are internal, so HI/LO stay stable during RUN.

## Timing

- Reset values:
  - State IDLE, `busy=0`, `done=0`, `dz=0`.
  - `hi` = 0, `lo` = 0, counter = 0.
- Start edge k:
  - `busy` is high from after edge k through edge k+W+1.
  - RUN occupies edges k+1..k+W; FIX is edge k+W+1.
  - `done` and the new `hi`/`lo` are visible after edge k+W+1.
  - `done` drops after edge k+W+2.
  - For W=32 the result is valid 33 cycles after the start edge.
- `start` while `busy`: ignored, with no effect on the operation in progress.
- `start` in the same cycle `done` is high: accepted, because the state is IDLE. `hi`/`lo` keep the just-completed values until the next FIX.
- `A`, `B` and `op` are sampled only on the start edge; later changes are ignored.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - No `done` pulse; the partial result is discarded.

## Configuration

- Macro: `MULDIV_SIGNED_EN`.
- Defined: MULT/DIV perform two's-complement signed arithmetic per the sign rules above.
- Undefined:
  - `op[0]` is ignored; MULT behaves as MULTU and DIV as DIVU.
  - No magnitude or sign-correction logic is built.
  - FIX still occupies one cycle, so latency is identical.

## Test plan

- MULTU with A=B=0xFFFFFFFF, start at edge k -> at edge k+33, `hi`=0xFFFFFFFE, `lo`=0x00000001, `done`=1 for exactly one cycle, and `busy` drops in the same cycle.
- MULT with A=-3, B=5 (`MULDIV_SIGNED_EN` defined) -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Same operands with the macro undefined -> `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIV with A=-7, B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `dz`=0. DIVU with A=100, B=7 -> `lo`=14, `hi`=2.
- DIVU with A=0x1234, B=0 -> `lo`=0xFFFFFFFF, `hi`=0x00001234, `dz`=1. DIV with A=0x80000000, B=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Start MULTU 6*7, then pulse `start` with DIVU operands at edge k+5 -> second request ignored; result `lo`=42, `hi`=0.
- Back-to-back: a new start asserted during the `done` cycle is accepted and completes 33 cycles later.
- Assert `rst` at edge k+10 of an operation -> `busy`=0, `hi`/`lo`=0, and no `done` pulse follows.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute-stage control and the iterative
// multiply/divide unit. The master drives the request; the slave (the unit)
// returns the handshake status and the HI/LO results.
interface muldiv_unit_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring-subtract
// (divide) step per cycle, W steps in RUN followed by one FIX cycle that applies
// sign correction and updates HI/LO.
// Optional feature macro: MULDIV_SIGNED_EN. When defined, MULT/DIV are signed
// two's-complement; when undefined, op[0] is ignored and no sign logic is built.
module muldiv_unit #(
    parameter int unsigned W = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    // Multiplicand (multiply) or divisor (divide) magnitude
    logic [W-1:0]    opd_q, opd_d;
    // Multiply: {upper, multiplier}; divide: {rem, quot}. The multiply carry
    // out of the upper half lands in the top bit after the shift.
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            dz_q, dz_d;
    logic            done_q, done_d;
`ifdef MULDIV_SIGNED_EN
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
`endif

    logic            accept;
    logic            last_step;
    logic [W-1:0]    a_mag, b_mag;
    logic            a_neg, b_neg;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_sh;
    logic [W-2:0]    quot_sh;
    logic            div_ge;
    logic [W-1:0]    div_sub;
    logic [2*W-1:0]  acc_step;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic [W-1:0]    res_hi, res_lo;
    logic            res_dz;

    assign accept    = (state_q == StIdle) && bus.start;
    assign last_step = (cnt_q == CntW'(W - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_step) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and result outputs
    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
        bus.dz   = dz_q;
    end

    // Operand magnitudes and signs, taken from the raw request inputs
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        a_neg = bus.op[0] & bus.A[W-1];
        b_neg = bus.op[0] & bus.B[W-1];
        a_mag = a_neg ? (~bus.A + W'(1)) : bus.A;
        b_mag = b_neg ? (~bus.B + W'(1)) : bus.B;
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
        a_mag = bus.A;
        b_mag = bus.B;
`endif
    end

    // One multiply or divide iteration on the working accumulator
    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});
        // Divide: {rem, quot} shifted left by one, split into its two halves
        rem_sh  = acc_q[2*W-1:W-1];
        quot_sh = acc_q[W-2:0];
        div_ge  = (rem_sh >= {1'b0, opd_q});
        // Only used when div_ge, where the difference is below 2^W
        div_sub = rem_sh[W-1:0] - opd_q;
        if (is_div_q) begin
            acc_step = div_ge ? {div_sub, quot_sh, 1'b1} : {rem_sh[W-1:0], quot_sh, 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
    end

    // Working-register next state: latch on accept, iterate during RUN
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opd_d     = opd_q;
        acc_d     = acc_q;
`ifdef MULDIV_SIGNED_EN
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    opd_d    = bus.op[1] ? b_mag : a_mag;
                    acc_d    = {{W{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
`endif
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CntW'(1);
            end
            default: ;
        endcase
    end

    // Sign correction and divide-by-zero handling of the final accumulator
    always_comb begin
        prod = acc_q;
        quot = acc_q[W-1:0];
        rem  = acc_q[2*W-1:W];
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = ~acc_q + (2*W)'(1);
            quot = ~acc_q[W-1:0] + W'(1);
        end
        if (rem_neg_q) begin
            rem = ~acc_q[2*W-1:W] + W'(1);
        end
`endif
        if (is_div_q) begin
            // A zero divisor lets every trial subtract succeed, so rem ends up
            // equal to the dividend magnitude and the sign-corrected rem is A.
            res_dz = (opd_q == '0);
            res_hi = rem;
            res_lo = res_dz ? {W{1'b1}} : quot;
        end else begin
            res_dz = 1'b0;
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end
    end

    // Architectural result next state: only the FIX cycle updates HI/LO
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        if (state_q == StFix) begin
            hi_d   = res_hi;
            lo_d   = res_lo;
            dz_d   = res_dz;
            done_d = 1'b1;
        end
    end

    // Working and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            opd_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opd_q     <= opd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (W=32) with hand-computed results.
// Expected values for signed ops follow MULDIV_SIGNED_EN as built.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [1:0] OpMultu = 2'b00;
    localparam logic [1:0] OpMult  = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpDiv   = 2'b11;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit_if #(.W(W)) bus ();

    muldiv_unit #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request, return 1ns after its start edge with the inputs scrambled
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = OpDiv;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h0;
    endtask

    // skip = edges already elapsed since the start edge
    task automatic finish_op(input string tag, input int skip, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input logic edz);
        repeat (W - skip) @(posedge clk);
        #1;
        check_eq({tag, "_busy_pre"}, 64'(bus.busy), 64'd1);
        check_eq({tag, "_done_pre"}, 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(bus.lo), 64'(el));
        check_eq({tag, "_dz"}, 64'(bus.dz), 64'(edz));
    endtask

    task automatic settle(input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic edz);
        start_op(op, a, b);
        finish_op(tag, 0, eh, el, edz);
        settle(tag);
    endtask

`ifdef MULDIV_SIGNED_EN
    localparam logic [W-1:0] MultHi  = 32'hFFFF_FFFF;
    localparam logic [W-1:0] MultLo  = 32'hFFFF_FFF1;
    localparam logic [W-1:0] Mult2Hi = 32'h0000_0000;
    localparam logic [W-1:0] DivQ    = 32'hFFFF_FFFD;
    localparam logic [W-1:0] DivR    = 32'hFFFF_FFFF;
    localparam logic [W-1:0] Div2Q   = 32'hFFFF_FFFD;
    localparam logic [W-1:0] Div2R   = 32'h0000_0001;
    localparam logic [W-1:0] OvfQ    = 32'h8000_0000;
    localparam logic [W-1:0] OvfR    = 32'h0000_0000;
`else
    localparam logic [W-1:0] MultHi  = 32'h0000_0004;
    localparam logic [W-1:0] MultLo  = 32'hFFFF_FFF1;
    localparam logic [W-1:0] Mult2Hi = 32'hFFFF_FFF6;
    localparam logic [W-1:0] DivQ    = 32'h7FFF_FFFC;
    localparam logic [W-1:0] DivR    = 32'h0000_0001;
    localparam logic [W-1:0] Div2Q   = 32'h0000_0000;
    localparam logic [W-1:0] Div2R   = 32'h0000_0007;
    localparam logic [W-1:0] OvfQ    = 32'h0000_0000;
    localparam logic [W-1:0] OvfR    = 32'h8000_0000;
`endif

    initial begin
        int seen_done;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_dz", 64'(bus.dz), 64'd0);
        check_eq("rst_hi", 64'(bus.hi), 64'd0);
        check_eq("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x5", OpMult, 32'hFFFF_FFFD, 32'd5, MultHi, MultLo, 1'b0);
        run_op("mult_m4xm6", OpMult, 32'hFFFF_FFFC, 32'hFFFF_FFFA, Mult2Hi, 32'd24, 1'b0);
        run_op("div_m7d2", OpDiv, 32'hFFFF_FFF9, 32'd2, DivR, DivQ, 1'b0);
        run_op("div_7dm2", OpDiv, 32'd7, 32'hFFFF_FFFE, Div2R, Div2Q, 1'b0);
        run_op("divu_100d7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_dz", OpDivu, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        check_eq("dz_held", 64'(bus.dz), 64'd1);
        run_op("div_neg_dz", OpDiv, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, OvfR, OvfQ, 1'b0);

        // Start while busy must be ignored
        start_op(OpMultu, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OpDivu;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("ign_hi_stable", 64'(bus.hi), 64'(OvfR));
        check_eq("ign_lo_stable", 64'(bus.lo), 64'(OvfQ));
        finish_op("ign", 5, 32'd0, 32'd42, 1'b0);
        settle("ign");

        // Back-to-back: new start accepted during the done cycle
        start_op(OpMultu, 32'd3, 32'd4);
        finish_op("b2b_first", 0, 32'd0, 32'd12, 1'b0);
        start_op(OpDivu, 32'd100, 32'd7);
        check_eq("b2b_busy", 64'(bus.busy), 64'd1);
        check_eq("b2b_lo_kept", 64'(bus.lo), 64'd12);
        finish_op("b2b_second", 0, 32'd2, 32'd14, 1'b0);
        settle("b2b");

        // Reset in the middle of an operation
        start_op(OpMultu, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_hi", 64'(bus.hi), 64'd0);
        check_eq("mid_rst_lo", 64'(bus.lo), 64'd0);
        check_eq("mid_rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done = 1;
        end
        check_eq("mid_rst_no_done", 64'(seen_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
